mem_cycle_ctrl: RTL and testbench
=================================

# mem_cycle_ctrl

Multi-cycle sequencer that drives the unified memory block of the memory-memory processor through one complete instruction: two-word fetch, operand read, execute hand-off, result write and optional clear. It sits between the top-level control/PC logic and the memory's address and write-enable ports, and is the only block that drives those ports. It accounts for the memory's registered-address, one-cycle read latency, and it never issues conflicting writes in the same cycle.

## Interface
- DATA_WIDTH, 16, width of addresses, data words and PC.
- clk  in  1  rising-edge clock shared with the memory.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  request to run one instruction at cmd_pc.
- cmd_ready  out  1  high only in IDLE.
- cmd_pc  in  DATA_WIDTH  address of instruction word 0.
- dec_valid  in  1  decoder has produced the fields below from ir0/ir1.
- dec_sr1, dec_sr2, dec_sr3, dec_rd  in  DATA_WIDTH each  operand and destination addresses.
- dec_wr, dec_clr  in  1 each  instruction writes rd; instruction zeroes mem[two].
- alu_valid  in  1  execute result ready.
- alu_result  in  DATA_WIDTH  value to write to rd.
- mem_iro, mem_irt, mem_out1, mem_out2, mem_out3  in  DATA_WIDTH each  memory read data.
- pc, two, sr1, sr2, sr3, rd  out  DATA_WIDTH each  memory address ports.
- data  out  DATA_WIDTH  memory write data.
- MEMWRITE, WRITEZERO  out  1 each  memory write strobes.
- ir0, ir1  out  DATA_WIDTH each  latched instruction words.
- op1, op2, op3  out  DATA_WIDTH each  latched operands.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at instruction completion.
- next_pc  out  DATA_WIDTH  cmd_pc + 2, valid from the cycle done pulses until the next command.

## Operation
- States: IDLE, FETCH, FETCH_LAT, DECODE, READ, READ_LAT, EXEC, WRITE, CLEAR, DONE.
- IDLE: when cmd_valid is high, capture cmd_pc and go to FETCH.
- FETCH: drive pc = cmd_pc and two = cmd_pc + 1. Go to FETCH_LAT.
- FETCH_LAT: latch ir0 = mem_iro and ir1 = mem_irt. Go to DECODE.
- DECODE: hold while dec_valid is low. When it is high, capture all dec_* fields and go to READ.
- READ: drive sr1, sr2 and sr3 from the captured addresses. Go to READ_LAT.
- READ_LAT: latch op1..op3 from mem_out1..3. Go to EXEC.
- EXEC: hold while alu_valid is low. When it is high, capture alu_result and go to:
  - WRITE if dec_wr,
  - else CLEAR if dec_clr,
  - else DONE.
- WRITE: MEMWRITE = 1, rd = captured rd, data = captured result. Go to CLEAR if dec_clr, else DONE.
- CLEAR: WRITEZERO = 1, two = cmd_pc + 1. Go to DONE.
- DONE: done = 1, next_pc updated. Go to IDLE.
- MEMWRITE and WRITEZERO are never high in the same cycle, even when rd equals two.
- All address arithmetic is modulo 2^DATA_WIDTH: cmd_pc = all-ones gives two = 0 and next_pc = 1.
- Address ports hold their last driven value outside their active state. Strobes are high only in WRITE or CLEAR.
- cmd_valid is ignored while busy; no queueing.
- When rst_n is asserted, the block goes immediately to IDLE. Every output, including ir*, op*, next_pc and all addresses, resets to 0.
- Reset mid-WRITE or mid-CLEAR drops the strobe asynchronously. A partial write is permitted; no retry is attempted.

## Timing
- Memory contract: an address driven in cycle N returns data on mem_* during cycle N+1. The *_LAT states sample on the edge that ends N+1.
- Minimum latency, cmd accept to done pulse: 8 cycles (dec_valid and alu_valid already high, dec_wr = 1, dec_clr = 0). Add 1 cycle for CLEAR; subtract 1 cycle with no write.
- DECODE and EXEC stall indefinitely; there is no timeout.
- cmd_ready rises in the cycle after DONE. Back-to-back commands are 9 cycles apart minimum.
- done and the strobes are Moore outputs, registered from state, with no combinational path from inputs.

## Structure
- Package mem_ctrl_pkg holds:
  - the state enum,
  - localparams PC_STEP = 2 and WORD1_OFS = 1.
- One sub-module is natural: mem_ctrl_fsm, containing the state register and next-state logic only. Address and operand registers stay in the top module.

## Test plan
- Basic ADD-like flow: cmd_pc = 0x0010, mem[0x10] = 0xA001, mem[0x11] = 0x0002, dec_sr1/2 = 0x20/0x21 holding 5 and 7, alu_result = 12, dec_rd = 0x22 → ir0 = 0xA001, ir1 = 0x0002, op1 = 5, op2 = 7, mem[0x22] = 12, done at cycle 8, next_pc = 0x0012.
- Clear flow: dec_wr = 1, dec_clr = 1, dec_rd = 0x11 → MEMWRITE in one cycle, WRITEZERO the next, final mem[0x11] = 0, done at cycle 9.
- Stalls: dec_valid held low 3 cycles, then alu_valid held low 2 cycles → done at cycle 13; address ports stable throughout the stalls.
- Wrap: cmd_pc = 0xFFFF → two = 0x0000, next_pc = 0x0001.
- Busy rejection: cmd_valid pulsed with cmd_pc = 0x40 during EXEC → ignored; no fetch at 0x40; cmd_ready = 0 until the cycle after done.
- Async reset during WRITE: rst_n low mid-cycle → MEMWRITE falls immediately; all outputs 0; state IDLE; cmd_ready = 1 on release.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_cycle_ctrl shared types
// state encoding and address offsets
package mem_ctrl_pkg;

  localparam int PC_STEP   = 2;
  localparam int WORD1_OFS = 1;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    FETCH_LAT,
    DECODE,
    READ,
    READ_LAT,
    EXEC,
    WRITE,
    CLEAR,
    DONE
  } state_t;

endpackage

// File: rtl/mem_ctrl_fsm.sv
// mem_cycle_ctrl sequencer
// state register and next-state logic
module mem_ctrl_fsm
  import mem_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   cmd_valid,
  input  logic   dec_valid,
  input  logic   alu_valid,
  input  logic   wr,
  input  logic   clr,
  output state_t state,
  output state_t state_nxt
);

  // next state; DECODE and EXEC wait on their valids
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (cmd_valid) state_nxt = FETCH;
      FETCH:     state_nxt = FETCH_LAT;
      FETCH_LAT: state_nxt = DECODE;
      DECODE:    if (dec_valid) state_nxt = READ;
      READ:      state_nxt = READ_LAT;
      READ_LAT:  state_nxt = EXEC;
      EXEC: begin
        if (alu_valid) begin
          if (wr)       state_nxt = WRITE;
          else if (clr) state_nxt = CLEAR;
          else          state_nxt = DONE;
        end
      end
      WRITE:     state_nxt = clr ? CLEAR : DONE;
      CLEAR:     state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

endmodule

// File: rtl/mem_cycle_ctrl.sv
// mem_cycle_ctrl top
// drives memory addresses/strobes for one instruction
module mem_cycle_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_pc,
  input  logic                  dec_valid,
  input  logic [DATA_WIDTH-1:0] dec_sr1,
  input  logic [DATA_WIDTH-1:0] dec_sr2,
  input  logic [DATA_WIDTH-1:0] dec_sr3,
  input  logic [DATA_WIDTH-1:0] dec_rd,
  input  logic                  dec_wr,
  input  logic                  dec_clr,
  input  logic                  alu_valid,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] mem_iro,
  input  logic [DATA_WIDTH-1:0] mem_irt,
  input  logic [DATA_WIDTH-1:0] mem_out1,
  input  logic [DATA_WIDTH-1:0] mem_out2,
  input  logic [DATA_WIDTH-1:0] mem_out3,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] two,
  output logic [DATA_WIDTH-1:0] sr1,
  output logic [DATA_WIDTH-1:0] sr2,
  output logic [DATA_WIDTH-1:0] sr3,
  output logic [DATA_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  MEMWRITE,
  output logic                  WRITEZERO,
  output logic [DATA_WIDTH-1:0] ir0,
  output logic [DATA_WIDTH-1:0] ir1,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2,
  output logic [DATA_WIDTH-1:0] op3,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] next_pc
);

  localparam logic [DATA_WIDTH-1:0] OFS1 =
    DATA_WIDTH'(WORD1_OFS);
  localparam logic [DATA_WIDTH-1:0] STEP =
    DATA_WIDTH'(PC_STEP);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] cpc;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  wr_q;
  logic                  clr_q;

  mem_ctrl_fsm u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .dec_valid (dec_valid),
    .alu_valid (alu_valid),
    .wr        (wr_q),
    .clr       (clr_q),
    .state     (state),
    .state_nxt (state_nxt)
  );

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // fetch: addresses set on entry so they are valid in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpc <= '0;
      pc  <= '0;
      ir0 <= '0;
      ir1 <= '0;
    end else begin
      if (state_nxt == FETCH && state == IDLE) begin
        cpc <= cmd_pc;
        pc  <= cmd_pc;
      end
      if (state == FETCH_LAT) begin
        ir0 <= mem_iro;
        ir1 <= mem_irt;
      end
    end
  end

  // two is shared by fetch of word 1 and the clear strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      two <= '0;
    end else if (state == IDLE && cmd_valid) begin
      two <= cmd_pc + OFS1;
    end else if (state_nxt == CLEAR) begin
      two <= cpc + OFS1;
    end
  end

  // decode capture and operand read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr1   <= '0;
      sr2   <= '0;
      sr3   <= '0;
      rd_q  <= '0;
      wr_q  <= 1'b0;
      clr_q <= 1'b0;
      op1   <= '0;
      op2   <= '0;
      op3   <= '0;
    end else begin
      if (state == DECODE && dec_valid) begin
        sr1   <= dec_sr1;
        sr2   <= dec_sr2;
        sr3   <= dec_sr3;
        rd_q  <= dec_rd;
        wr_q  <= dec_wr;
        clr_q <= dec_clr;
      end
      if (state == READ_LAT) begin
        op1 <= mem_out1;
        op2 <= mem_out2;
        op3 <= mem_out3;
      end
    end
  end

  // writeback, strobes and completion, all from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd        <= '0;
      data      <= '0;
      next_pc   <= '0;
      MEMWRITE  <= 1'b0;
      WRITEZERO <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (state_nxt == WRITE) begin
        rd   <= rd_q;
        data <= alu_result;
      end
      if (state_nxt == DONE) next_pc <= cpc + STEP;
      MEMWRITE  <= (state_nxt == WRITE);
      WRITEZERO <= (state_nxt == CLEAR);
      done      <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// mem_cycle_ctrl testbench
// vector table + scoreboard, memory model
module tb_mem_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_pc;
  logic        dec_valid, dec_wr, dec_clr;
  logic [15:0] dec_sr1, dec_sr2, dec_sr3, dec_rd;
  logic        alu_valid;
  logic [15:0] alu_result;
  logic [15:0] mem_iro, mem_irt;
  logic [15:0] mem_out1, mem_out2, mem_out3;
  logic [15:0] pc, two, sr1, sr2, sr3, rd, data;
  logic        MEMWRITE, WRITEZERO, busy, done;
  logic [15:0] ir0, ir1, op1, op2, op3, next_pc;

  always #5 clk = ~clk;

  mem_cycle_ctrl #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pc(cmd_pc), .dec_valid(dec_valid),
    .dec_sr1(dec_sr1), .dec_sr2(dec_sr2),
    .dec_sr3(dec_sr3), .dec_rd(dec_rd),
    .dec_wr(dec_wr), .dec_clr(dec_clr),
    .alu_valid(alu_valid), .alu_result(alu_result),
    .mem_iro(mem_iro), .mem_irt(mem_irt),
    .mem_out1(mem_out1), .mem_out2(mem_out2),
    .mem_out3(mem_out3),
    .pc(pc), .two(two), .sr1(sr1), .sr2(sr2),
    .sr3(sr3), .rd(rd), .data(data),
    .MEMWRITE(MEMWRITE), .WRITEZERO(WRITEZERO),
    .ir0(ir0), .ir1(ir1), .op1(op1), .op2(op2),
    .op3(op3), .busy(busy), .done(done),
    .next_pc(next_pc)
  );

  // memory: registered address, one-cycle read latency
  logic [15:0] mem [0:65535];
  logic        tb_we = 1'b0;
  logic [15:0] tb_wa = '0;
  logic [15:0] tb_wd = '0;

  always @(posedge clk) begin
    mem_iro  <= mem[pc];
    mem_irt  <= mem[two];
    mem_out1 <= mem[sr1];
    mem_out2 <= mem[sr2];
    mem_out3 <= mem[sr3];
    if (tb_we)     mem[tb_wa] <= tb_wd;
    if (MEMWRITE)  mem[rd]    <= data;
    if (WRITEZERO) mem[two]   <= 16'h0000;
  end

  typedef struct {
    logic [15:0] pc, w0, w1, a1, a2, a3;
    logic [15:0] v1, v2, v3, rd, res, npc;
    bit          wr, clr, poke;
    int          ds, as_, lat;
  } vec_t;

  typedef struct {
    logic [15:0] pc, two, ir0, ir1;
    logic [15:0] op1, op2, op3, npc;
    int          lat;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  vec_t vt[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [15:0] pc, w0, w1, a1, a2, a3,
    input logic [15:0] v1, v2, v3, rd, res, npc,
    input bit wr, clr, poke,
    input int ds, as_, lat);
    vec_t v;
    v.pc = pc; v.w0 = w0; v.w1 = w1;
    v.a1 = a1; v.a2 = a2; v.a3 = a3;
    v.v1 = v1; v.v2 = v2; v.v3 = v3;
    v.rd = rd; v.res = res; v.npc = npc;
    v.wr = wr; v.clr = clr; v.poke = poke;
    v.ds = ds; v.as_ = as_; v.lat = lat;
    return v;
  endfunction

  task automatic poke(input logic [15:0] a,
                      input logic [15:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic setup(input vec_t v);
    poke(v.rd, 16'h9999);
    poke(v.pc, v.w0);
    poke(v.pc + 16'd1, v.w1);
    poke(v.a1, v.v1);
    poke(v.a2, v.v2);
    poke(v.a3, v.v3);
    dec_sr1 = v.a1; dec_sr2 = v.a2;
    dec_sr3 = v.a3; dec_rd = v.rd;
    dec_wr = v.wr; dec_clr = v.clr;
    alu_result = v.res;
    dec_valid = 1'b0; alu_valid = 1'b0;
  endtask

  task automatic issue(input logic [15:0] a);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    cmd_pc = a; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_pc = 16'h0000;
  endtask

  task automatic run(input string tag, input vec_t v);
    exp_t        e;
    logic [15:0] m;
    logic [95:0] snap, cur;
    int j = 0, lat = 0, ovl = 0, rdyb = 0;
    int wcnt = 0, zcnt = 0, wcy = -1, zcy = -1;
    int moves = 0;
    bit seen = 0;
    setup(v);
    e.pc = v.pc; e.two = v.pc + 16'd1;
    e.ir0 = v.w0; e.ir1 = v.w1;
    e.op1 = v.v1; e.op2 = v.v2; e.op3 = v.v3;
    e.npc = v.npc; e.lat = v.lat;
    sbq.push_back(e);
    issue(v.pc);
    while (!seen && j < 40) begin
      dec_valid = (j >= 2 + v.ds);
      alu_valid = (j >= 5 + v.ds + v.as_);
      if (v.poke && j == 6 + v.ds) begin
        cmd_valid = 1'b1; cmd_pc = 16'h0040;
      end else begin
        cmd_valid = 1'b0; cmd_pc = 16'h0000;
      end
      @(negedge clk);
      cur = {pc, two, sr1, sr2, sr3, rd};
      if (j == 2 || j == 5 + v.ds) snap = cur;
      if (j > 2 && j <= 2 + v.ds && cur != snap)
        moves++;
      if (j > 5 + v.ds && j <= 5 + v.ds + v.as_
          && cur != snap)
        moves++;
      if (MEMWRITE && WRITEZERO) ovl++;
      if (MEMWRITE) begin wcnt++; wcy = j; end
      if (WRITEZERO) begin zcnt++; zcy = j; end
      if (cmd_ready) rdyb++;
      if (done) begin
        seen = 1;
        lat = j + 1;
        if (sbq.size() == 0) begin
          chk({tag, " sb_empty"}, 1, 0);
        end else begin
          e = sbq.pop_front();
          chk({tag, " ir0"}, ir0, e.ir0);
          chk({tag, " ir1"}, ir1, e.ir1);
          chk({tag, " op1"}, op1, e.op1);
          chk({tag, " op2"}, op2, e.op2);
          chk({tag, " op3"}, op3, e.op3);
          chk({tag, " next_pc"}, next_pc, e.npc);
          chk({tag, " latency"}, lat, e.lat);
          chk({tag, " pc"}, pc, e.pc);
          chk({tag, " two"}, two, e.two);
        end
      end
      @(posedge clk); #1;
      j++;
    end
    cmd_valid = 1'b0;
    if (!seen) begin
      chk({tag, " done_timeout"}, 0, 1);
      if (sbq.size() != 0) void'(sbq.pop_front());
    end
    chk({tag, " ready_after"}, {cmd_ready, busy}, 2'b10);
    chk({tag, " ready_busy"}, rdyb, 0);
    chk({tag, " strobe_ovl"}, ovl, 0);
    chk({tag, " wr_cnt"}, wcnt, v.wr);
    chk({tag, " clr_cnt"}, zcnt, v.clr);
    chk({tag, " addr_stall"}, moves, 0);
    if (v.wr && v.clr) chk({tag, " wr_then_clr"}, zcy, wcy + 1);
    m = (v.rd == v.pc + 16'd1) ? v.w1 : 16'h9999;
    if (v.wr) m = v.res;
    if (v.clr && v.rd == v.pc + 16'd1) m = 16'h0000;
    chk({tag, " mem_rd"}, mem[v.rd], m);
    if (v.clr) chk({tag, " mem_two"}, mem[v.pc + 16'd1], 0);
    @(posedge clk); #1;
    chk({tag, " idle_hold"}, busy, 0);
  endtask

  task automatic reset_mid_write();
    vec_t v;
    int   n = 0;
    v = mk(16'h0400, 16'h2008, 16'h0000, 16'h0410,
           16'h0411, 16'h0412, 1, 2, 3, 16'h0420,
           16'h6666, 16'h0402, 1, 1, 0, 0, 0, 9);
    setup(v);
    dec_valid = 1'b1; alu_valid = 1'b1;
    issue(v.pc);
    while (n < 20) begin
      @(negedge clk);
      if (MEMWRITE) break;
      n++;
    end
    chk("rstw write_seen", MEMWRITE, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw strobes", {MEMWRITE, WRITEZERO, done}, 0);
    chk("rstw outs", |{pc, two, sr1, sr2, sr3, rd,
        data, ir0, ir1, op1, op2, op3, next_pc,
        busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstw release", {cmd_ready, busy}, 2'b10);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_pc = '0;
    dec_valid = 1'b0; alu_valid = 1'b0;
    dec_sr1 = '0; dec_sr2 = '0; dec_sr3 = '0;
    dec_rd = '0; dec_wr = 1'b0; dec_clr = 1'b0;
    alu_result = '0;

    vt[0] = mk(16'h0010, 16'hA001, 16'h0002, 16'h0020,
               16'h0021, 16'h0023, 16'd5, 16'd7, 16'd9,
               16'h0022, 16'd12, 16'h0012, 1, 0, 0, 0, 0, 8);
    vt[1] = mk(16'h0010, 16'hC003, 16'h0011, 16'h0024,
               16'h0025, 16'h0026, 16'h1111, 16'h2222,
               16'h3333, 16'h0011, 16'h0055, 16'h0012,
               1, 1, 0, 0, 0, 9);
    vt[2] = mk(16'h0100, 16'hD004, 16'h0104, 16'h0120,
               16'h0121, 16'h0122, 16'hAAAA, 16'hBBBB,
               16'hCCCC, 16'h0130, 16'h0BAD, 16'h0102,
               1, 0, 0, 3, 2, 13);
    vt[3] = mk(16'hFFFF, 16'hE005, 16'h1234, 16'h0050,
               16'h0051, 16'h0052, 16'd1, 16'd2, 16'd3,
               16'h0060, 16'h7777, 16'h0001, 0, 1, 0, 0, 0, 8);
    vt[4] = mk(16'h0200, 16'hF006, 16'h0201, 16'h0210,
               16'h0211, 16'h0212, 16'h0101, 16'h0202,
               16'h0303, 16'h0220, 16'h4444, 16'h0202,
               1, 0, 1, 0, 3, 11);
    vt[5] = mk(16'h0300, 16'h1007, 16'h0300, 16'h0310,
               16'h0311, 16'h0312, 16'h00FF, 16'hFF00,
               16'h0F0F, 16'h0320, 16'h5555, 16'h0302,
               0, 0, 0, 0, 0, 7);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outs", |{pc, two, sr1, sr2, sr3, rd,
        data, ir0, ir1, op1, op2, op3, next_pc}, 0);
    chk("reset ctl", {MEMWRITE, WRITEZERO, busy, done}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset ready", cmd_ready, 1);

    for (int i = 0; i < 6; i++)
      run($sformatf("v%0d", i), vt[i]);

    reset_mid_write();
    run("v0_again", vt[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
